mem_port_arbiter: RTL and testbench

//  Shares one single-port synchronous RAM between the instruction-fetch port and the load/store port.

---
 rtl/mem_port_arbiter.sv | 98 +++++++++
 tb/tb_mem_port_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one synchronous RAM between instruction fetch and load/store.
// Load/store has priority except when fetch has been denied MAX_WAIT cycles.
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [DATA_W/8-1:0] ls_be,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  output logic                ls_gnt,
  output logic                ls_rvalid,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                mem_en,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam logic [3:0] MAXW = 4'(MAX_WAIT);

  typedef enum logic [1:0] {
    RSP_IDLE,
    RSP_IF,
    RSP_LS
  } rsp_e;

  rsp_e       rsp_st_q, rsp_st_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       starve;

  assign starve = if_req && (wait_cnt_q == MAXW);

  always_comb begin
    ls_gnt = !rst && ls_req && !starve;
    if_gnt = !rst && if_req && !ls_gnt;
  end

  always_comb begin
    mem_en    = if_gnt || ls_gnt;
    mem_we    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (ls_gnt) begin
      mem_addr  = ls_addr;
      mem_wdata = ls_wdata;
      if (ls_we) mem_we = ls_be;
    end else if (if_gnt) begin
      mem_addr = if_addr;
    end
  end

  // Saturating count of consecutive denied fetch cycles.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!if_req || if_gnt)
      wait_cnt_d = '0;
    else if (wait_cnt_q != MAXW)
      wait_cnt_d = wait_cnt_q + 4'd1;
  end

  always_comb begin
    rsp_st_d = RSP_IDLE;
    unique case (1'b1)
      if_gnt:           rsp_st_d = RSP_IF;
      ls_gnt && !ls_we: rsp_st_d = RSP_LS;
      default:          rsp_st_d = RSP_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_st_q   <= RSP_IDLE;
      wait_cnt_q <= '0;
    end else begin
      rsp_st_q   <= rsp_st_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    if_rvalid = (rsp_st_q == RSP_IF);
    ls_rvalid = (rsp_st_q == RSP_LS);
    if_rdata  = if_rvalid ? mem_rdata : '0;
    ls_rdata  = ls_rvalid ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 1-cycle RAM.
// Checks are immediate assertions counted into the summary line.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        ls_req, ls_we, ls_gnt, ls_rvalid;
  logic [3:0]  ls_be, mem_we;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic        mem_en;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be),
    .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_gnt(ls_gnt),
    .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // RAM: word i holds 0xC0DE0000|(4*i), word 0x200/4 holds 0x11223344.
  logic [31:0] ram [0:255];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++)
        ram[i] <= 32'hC0DE_0000 | 32'(i * 4);
      ram[128] <= 32'h1122_3344;
      mem_rdata <= '0;
    end else if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) ram[mem_addr[9:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      mem_rdata <= ram[mem_addr[9:2]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    if_req = 1'b1; if_addr = 32'h0;
    ls_req = 1'b1; ls_we = 1'b0; ls_be = 4'h0;
    ls_addr = 32'h40; ls_wdata = 32'h0;

    // Reset with both requests pending
    repeat (3) tick();
    chk("rst_if_gnt", 32'(if_gnt), 32'd0);
    chk("rst_ls_gnt", 32'(ls_gnt), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_if_rvalid", 32'(if_rvalid), 32'd0);
    chk("rst_ls_rvalid", 32'(ls_rvalid), 32'd0);
    rst = 1'b0;
    #1;
    chk("rel_ls_rvalid", 32'(ls_rvalid), 32'd0);
    chk("rel_if_rvalid", 32'(if_rvalid), 32'd0);
    chk("rel_ls_gnt", 32'(ls_gnt), 32'd1);
    chk("rel_if_gnt", 32'(if_gnt), 32'd0);
    tick();
    chk("rel_ls_rvalid2", 32'(ls_rvalid), 32'd1);
    chk("rel_ls_rdata", ls_rdata, 32'hC0DE_0040);
    if_req = 1'b0; ls_req = 1'b0;
    #1;
    chk("idle_mem_en", 32'(mem_en), 32'd0);
    chk("idle_mem_addr", mem_addr, 32'd0);
    tick();
    chk("idle_ls_rvalid", 32'(ls_rvalid), 32'd0);

    // Fetch-only back-to-back
    if_req = 1'b1; if_addr = 32'h0;
    #1;
    chk("f0_gnt", 32'(if_gnt), 32'd1);
    chk("f0_addr", mem_addr, 32'h0);
    tick();
    if_addr = 32'h4;
    #1;
    chk("f0_rvalid", 32'(if_rvalid), 32'd1);
    chk("f0_rdata", if_rdata, 32'hC0DE_0000);
    chk("f1_gnt", 32'(if_gnt), 32'd1);
    tick();
    if_addr = 32'h8;
    #1;
    chk("f1_rdata", if_rdata, 32'hC0DE_0004);
    chk("f2_gnt", 32'(if_gnt), 32'd1);
    tick();
    if_req = 1'b0;
    #1;
    chk("f2_rdata", if_rdata, 32'hC0DE_0008);
    tick();
    chk("f_done_rvalid", 32'(if_rvalid), 32'd0);
    chk("f_done_rdata", if_rdata, 32'd0);

    // Load/fetch conflict
    if_req = 1'b1; if_addr = 32'h10;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h100;
    #1;
    chk("c_ls_gnt", 32'(ls_gnt), 32'd1);
    chk("c_if_gnt", 32'(if_gnt), 32'd0);
    chk("c_addr", mem_addr, 32'h100);
    tick();
    ls_req = 1'b0;
    #1;
    chk("c_ls_rvalid", 32'(ls_rvalid), 32'd1);
    chk("c_ls_rdata", ls_rdata, 32'hC0DE_0100);
    chk("c_if_gnt2", 32'(if_gnt), 32'd1);
    chk("c_if_rvalid0", 32'(if_rvalid), 32'd0);
    tick();
    if_req = 1'b0;
    #1;
    chk("c_if_rvalid", 32'(if_rvalid), 32'd1);
    chk("c_if_rdata", if_rdata, 32'hC0DE_0010);
    chk("c_ls_rvalid2", 32'(ls_rvalid), 32'd0);
    tick();

    // Starvation: fetch wins in cycles 5 and 10
    if_req = 1'b1; if_addr = 32'h20;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h44;
    for (int c = 1; c <= 10; c++) begin
      #1;
      chk($sformatf("st_if_gnt_c%0d", c), 32'(if_gnt),
          32'((c == 5) || (c == 10)));
      chk($sformatf("st_ls_gnt_c%0d", c), 32'(ls_gnt),
          32'(!((c == 5) || (c == 10))));
      tick();
    end
    if_req = 1'b0; ls_req = 1'b0;
    tick();

    // Partial store then read back
    ls_req = 1'b1; ls_we = 1'b1; ls_be = 4'b0011;
    ls_addr = 32'h200; ls_wdata = 32'hDEAD_BEEF;
    #1;
    chk("s_gnt", 32'(ls_gnt), 32'd1);
    chk("s_mem_we", 32'(mem_we), 32'h3);
    chk("s_wdata", mem_wdata, 32'hDEAD_BEEF);
    tick();
    ls_req = 1'b0;
    #1;
    chk("s_no_rvalid", 32'(ls_rvalid), 32'd0);
    ls_req = 1'b1; ls_we = 1'b0;
    #1;
    chk("s_ld_we", 32'(mem_we), 32'd0);
    tick();
    ls_req = 1'b0;
    #1;
    chk("s_ld_rvalid", 32'(ls_rvalid), 32'd1);
    chk("s_ld_rdata", ls_rdata, 32'h1122_BEEF);
    tick();

    // Reset mid-read
    if_req = 1'b1; if_addr = 32'h30;
    tick();
    rst = 1'b1; ls_req = 1'b1;
    #1;
    chk("rm_if_rvalid", 32'(if_rvalid), 32'd0);
    chk("rm_if_gnt", 32'(if_gnt), 32'd0);
    tick();
    rst = 1'b0; if_req = 1'b0; ls_req = 1'b0;
    #1;
    chk("rm_rel_rvalid", 32'(if_rvalid), 32'd0);
    chk("rm_wait_cnt", 32'(dut.wait_cnt_q), 32'd0);
    tick();
    chk("rm_rel_rvalid2", 32'(if_rvalid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
